// File: rtl/wshb_arbiter_rr_pkg.sv
// rtl/wshb_arbiter_rr_pkg.sv - shared Wishbone widths and arbiter state type
package wshb_arbiter_rr_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wshb_arbiter_rr_if.sv
// rtl/wshb_arbiter_rr_if.sv - N-master / 1-slave Wishbone bundle seen by the arbiter
interface wshb_arbiter_rr_if #(
  parameter int N_MASTERS = 2
);
  import wshb_arbiter_rr_pkg::*;

  logic [N_MASTERS-1:0]       m_cyc;
  logic [N_MASTERS-1:0]       m_stb;
  logic [N_MASTERS-1:0]       m_we;
  logic [N_MASTERS*ADR_W-1:0] m_adr;
  logic [N_MASTERS*SEL_W-1:0] m_sel;
  logic [N_MASTERS*DAT_W-1:0] m_dat_ms;
  logic [N_MASTERS-1:0]       m_ack;
  logic [N_MASTERS-1:0]       m_err;
  logic [DAT_W-1:0]           m_dat_sm;

  logic                       s_cyc;
  logic                       s_stb;
  logic                       s_we;
  logic [ADR_W-1:0]           s_adr;
  logic [SEL_W-1:0]           s_sel;
  logic [DAT_W-1:0]           s_dat_ms;
  logic                       s_ack;
  logic                       s_err;
  logic [DAT_W-1:0]           s_dat_sm;

  // Arbiter view: slave towards the clients, master towards the SDRAM port.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms, s_ack, s_err, s_dat_sm,
    output m_ack, m_err, m_dat_sm, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms, s_ack, s_err, s_dat_sm,
    input  m_ack, m_err, m_dat_sm, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms
  );

endinterface

// File: rtl/wshb_arbiter_rr_picker.sv
// rtl/wshb_arbiter_rr_picker.sv - round-robin pick: first requester after last, wrapping
module wshb_rr_picker #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int pos;

  // Scan farthest-first so the nearest requester after last_i is written last and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(last_i) + k) % N;
      if (req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter_rr.sv
// rtl/wshb_arbiter_rr.sv - N:1 Wishbone round-robin interconnect with ack watchdog
module wshb_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 255
) (
  input logic                 clk,
  input logic                 rst,
  wshb_arbiter_rr_if.slave    bus
);
  import wshb_arbiter_rr_pkg::*;

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] pick_last;
  logic             owner_cyc;
  logic             owner_stb;
  logic             wd_abort;
  logic             stalled;

  // In OWN a release re-picks starting after the current owner.
  assign pick_last = (state_q == OWN) ? owner_q : last_q;

  wshb_rr_picker #(.N(N_MASTERS)) u_picker (
    .req_i   (bus.m_cyc),
    .last_i  (pick_last),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign owner_cyc = bus.m_cyc[owner_q];
  assign owner_stb = bus.m_stb[owner_q];
  assign wd_abort  = (TIMEOUT > 0) && (state_q == OWN) && (wd_q == WD_W'(TIMEOUT));
  assign stalled   = (state_q == OWN) && owner_cyc && owner_stb && !wd_abort
                     && !bus.s_ack && !bus.s_err;
  assign bus.m_dat_sm = bus.s_dat_sm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          owner_d = pick_idx;
        end
      end
      OWN: begin
        if (!owner_cyc) begin
          last_d = owner_q;
          if (pick_valid) owner_d = pick_idx;
          else            state_d = IDLE;
        end else if (stalled && (TIMEOUT > 0)) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_cyc    = 1'b0;
    bus.s_stb    = 1'b0;
    bus.s_we     = 1'b0;
    bus.s_adr    = '0;
    bus.s_sel    = '0;
    bus.s_dat_ms = '0;
    bus.m_ack    = '0;
    bus.m_err    = '0;
    if (state_q == OWN) begin
      bus.s_cyc          = owner_cyc && !wd_abort;
      bus.s_stb          = owner_stb && !wd_abort;
      bus.s_we           = bus.m_we[owner_q];
      bus.s_adr          = bus.m_adr[int'(owner_q)*ADR_W +: ADR_W];
      bus.s_sel          = bus.m_sel[int'(owner_q)*SEL_W +: SEL_W];
      bus.s_dat_ms       = bus.m_dat_ms[int'(owner_q)*DAT_W +: DAT_W];
      bus.m_ack[owner_q] = bus.s_ack;
      bus.m_err[owner_q] = bus.s_err || wd_abort;
    end
  end

endmodule
